visor_snapshot_engine: RTL and testbench
========================================

Name: visor_snapshot_engine

Overview:
- Hardware successor to the hand-coded supervisor breakpoint/peek loop.
- Watches target fetch addresses against NUM_BP breakpoints. On a hit it holds the target and diverts its code bus, then forces a debug_peek_reg opcode for each register selected in a mask.
- Streams each captured value out, restores the target's pending opcode, releases the target, and passes the breakpoint once.
- Sits between the visor MCU's config registers and the target's tg_force/bus_ctrl controls.

Parameters:
- NUM_BP, 4: number of breakpoint comparators.
- WIDTH, 16: target address/data/opcode width.
- NUM_REGS, 16: number of target registers that can be peeked.
- PEEK_BASE, 16'h7c00: peek opcode. The forced opcode is PEEK_BASE | reg_index.
- TIMEOUT, 15: maximum cycles to wait for peek_valid after an exec.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_bp_addr  in  NUM_BP*WIDTH  breakpoint addresses; slot i is bits [i*WIDTH +: WIDTH].
- cfg_bp_en  in  NUM_BP  per-slot enable.
- cfg_reg_mask  in  NUM_REGS  registers to snapshot; bit n selects rn.
- cfg_continuous  in  1  1 = re-arm after each snapshot; 0 = one-shot.
- arm  in  1  pulse: IDLE -> ARMED.
- disarm  in  1  pulse: ARMED -> IDLE.
- tg_fetch  in  1  target fetch strobe.
- tg_code_addr  in  WIDTH  target fetch address.
- exr_shadow  in  WIDTH  target's pending opcode.
- peek_valid  in  1  target has produced peek_data.
- peek_data  in  WIDTH  peeked register value.
- tg_hold  out  1  hold target state.
- divert_code_bus  out  1  target fetches from force_opcode.
- tg_force_load_exr  out  1  one-cycle load of force_opcode into the target's exr.
- tg_force_exec  out  1  one-cycle forced execute.
- force_opcode  out  WIDTH  opcode presented to the target.
- snap_wr  out  1  one-cycle strobe: snapshot entry valid.
- snap_idx  out  $clog2(NUM_REGS)  register index of the entry.
- snap_data  out  WIDTH  captured value; 0 on timeout.
- snap_err  out  1  entry timed out.
- hit_id  out  $clog2(NUM_BP)  slot of the last hit.
- hit_count  out  16  total hits, saturating at 16'hffff.
- busy  out  1  high in any state other than IDLE or ARMED.
- done  out  1  one-cycle pulse when the target is released.

Behaviour:
- Reset (reset_n=0 at a clk edge) forces state IDLE and drives every output to 0.
  - This includes tg_hold and divert_code_bus, so a reset in mid-sequence releases the target immediately.
  - No restore of the target's exr is attempted.
- States: IDLE, ARMED, HOLD, LOAD, EXEC, WAIT, RESTORE, RELEASE, PASS.
- IDLE:
  - arm -> ARMED.
  - disarm is ignored.
  - arm is ignored in every state except IDLE.
- ARMED:
  - Hit condition: tg_fetch && cfg_bp_en[i] && tg_code_addr == slot i.
  - When several slots hit, the lowest i wins; that i is latched into hit_id and the saturating hit_count increments.
  - On a hit -> HOLD. tg_hold and divert_code_bus rise on the cycle after the hit cycle.
  - disarm with no hit in the same cycle -> IDLE. A hit takes priority over a simultaneous disarm.
- HOLD:
  - Latch exr_shadow.
  - Select the lowest set bit of cfg_reg_mask, sampled at entry into HOLD; later mask changes are ignored until the next hit.
  - Mask empty -> RESTORE; otherwise -> LOAD.
- LOAD: force_opcode = PEEK_BASE | idx; tg_force_load_exr=1 for exactly 1 cycle -> EXEC.
- EXEC: tg_force_exec=1 for 1 cycle; clear the timeout counter -> WAIT.
- WAIT:
  - On peek_valid: snap_wr=1 for 1 cycle with snap_idx=idx, snap_data=peek_data, snap_err=0.
  - If the counter reaches TIMEOUT without peek_valid: snap_wr=1 with snap_data=0, snap_err=1.
  - In either case, advance to the next set mask bit -> LOAD. If no set bits remain -> RESTORE.
  - peek_valid outside WAIT is ignored.
- RESTORE: force_opcode = latched exr_shadow; tg_force_load_exr=1 for 1 cycle -> RELEASE.
- RELEASE: tg_hold=0, divert_code_bus=0, done=1 for 1 cycle -> PASS.
- PASS:
  - Comparator hit_id is masked until a tg_fetch occurs with tg_code_addr != its address (pass once). Other slots are also masked during PASS.
  - Then -> ARMED if cfg_continuous, else -> IDLE.
- tg_hold and divert_code_bus are held high in every state from HOLD through RESTORE inclusive.
- force_opcode holds its last value outside LOAD/RESTORE.
- Per-register cost with no timeout: LOAD + EXEC + WAIT (at least 1 cycle) = 3 cycles minimum.

Test Plan:
- Single hit, full snapshot:
  - Stimulus: arm; slot0 = 16'h0015, enabled; mask = 16'h0080; target returns 16'hbeef one cycle after exec; fetch at 0x0015.
  - Required: hold rises the cycle after the fetch; LOAD shows force_opcode = 16'h7c07; snap_wr with idx = 7, data = 16'hbeef; RESTORE shows force_opcode = exr_shadow (16'h1234); done; hit_count = 1.
- Multi-register mask:
  - Stimulus: mask = 16'h8005.
  - Required: exactly three snap_wr strobes with idx 0, 2, 15 in order; force opcodes 7c00, 7c02, 7c0f.
- Simultaneous hit:
  - Stimulus: slots 1 and 3 both = 16'h0040, both enabled; fetch at 0x40.
  - Required: hit_id = 1.
- Pass-once, continuous:
  - Stimulus: cfg_continuous = 1; after done, repeated fetches at 0x15, then a fetch at 0x16, then at 0x15 again.
  - Required: no re-hit until the 0x16 fetch; a second snapshot occurs; hit_count = 2.
- Timeout:
  - Stimulus: peek_valid never asserted; mask = 16'h0002.
  - Required: after 15 WAIT cycles, snap_wr with idx = 1, data = 0, err = 1; target still restored and released.
- Reset mid-WAIT and empty mask:
  - Stimulus: deassert reset_n during WAIT.
  - Required: next cycle all outputs 0 and state IDLE; arm is required before any new hit.
  - Stimulus: mask = 0 with a hit.
  - Required: HOLD -> RESTORE directly, no snap_wr, done pulses.

Source files
------------

// File: rtl/visor_snapshot_engine.sv
// Breakpoint-driven register snapshot engine: on a fetch hit it holds the target,
// forces a peek opcode per selected register, streams results, then restores and releases.
module visor_snapshot_engine #(
    parameter int                 NUM_BP    = 4,
    parameter int                 WIDTH     = 16,
    parameter int                 NUM_REGS  = 16,
    parameter logic [WIDTH-1:0]   PEEK_BASE = 16'h7c00,
    parameter int                 TIMEOUT   = 15,
    localparam int                BPW       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
    localparam int                IDXW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_BP*WIDTH-1:0]  cfg_bp_addr,
    input  logic [NUM_BP-1:0]        cfg_bp_en,
    input  logic [NUM_REGS-1:0]      cfg_reg_mask,
    input  logic                     cfg_continuous,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic                     tg_fetch,
    input  logic [WIDTH-1:0]         tg_code_addr,
    input  logic [WIDTH-1:0]         exr_shadow,
    input  logic                     peek_valid,
    input  logic [WIDTH-1:0]         peek_data,
    output logic                     tg_hold,
    output logic                     divert_code_bus,
    output logic                     tg_force_load_exr,
    output logic                     tg_force_exec,
    output logic [WIDTH-1:0]         force_opcode,
    output logic                     snap_wr,
    output logic [IDXW-1:0]          snap_idx,
    output logic [WIDTH-1:0]         snap_data,
    output logic                     snap_err,
    output logic [BPW-1:0]           hit_id,
    output logic [15:0]              hit_count,
    output logic                     busy,
    output logic                     done
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0, S_ARMED   = 4'd1, S_HOLD    = 4'd2,
        S_LOAD    = 4'd3, S_EXEC    = 4'd4, S_WAIT    = 4'd5,
        S_RESTORE = 4'd6, S_RELEASE = 4'd7, S_PASS    = 4'd8
    } state_t;

    state_t               state_r;
    logic [NUM_REGS-1:0]  mask_r;
    logic [IDXW-1:0]      idx_r;
    logic [WIDTH-1:0]     exr_r;
    logic [TW-1:0]        tmo_cnt_r;
    logic                 tg_hold_r, divert_r, load_exr_r, exec_r, snap_wr_r, snap_err_r;
    logic                 busy_r, done_r;
    logic [WIDTH-1:0]     force_opcode_r, snap_data_r;
    logic [IDXW-1:0]      snap_idx_r;
    logic [BPW-1:0]       hit_id_r;
    logic [15:0]          hit_count_r;

    logic                 hit_any_s;
    logic [BPW-1:0]       hit_idx_s;
    logic [NUM_REGS-1:0]  mask_rest_s;
    logic [IDXW-1:0]      first_idx_s, next_idx_s;
    logic [WIDTH-1:0]     pass_addr_s;

    function automatic logic [IDXW-1:0] lowest_bit(input logic [NUM_REGS-1:0] m);
        lowest_bit = {IDXW{1'b0}};
        for (int n = NUM_REGS - 1; n >= 0; n--) begin
            if (m[n]) lowest_bit = IDXW'(n);
            else      lowest_bit = lowest_bit;
        end
    endfunction

    function automatic logic [WIDTH-1:0] peek_op(input logic [IDXW-1:0] idx);
        peek_op = PEEK_BASE | WIDTH'(idx);
    endfunction

    // Breakpoint comparators; scanning downward leaves the lowest hitting slot as winner.
    always_comb begin
        hit_any_s = 1'b0;
        hit_idx_s = {BPW{1'b0}};
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (tg_fetch && cfg_bp_en[i] && (tg_code_addr == cfg_bp_addr[i*WIDTH +: WIDTH])) begin
                hit_any_s = 1'b1;
                hit_idx_s = BPW'(i);
            end else begin
                hit_any_s = hit_any_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Remaining register selection and the address that must be fetched past before re-arming.
    always_comb begin
        mask_rest_s = mask_r & ~({{(NUM_REGS-1){1'b0}}, 1'b1} << idx_r);
        first_idx_s = lowest_bit(mask_r);
        next_idx_s  = lowest_bit(mask_rest_s);
        pass_addr_s = cfg_bp_addr[int'(hit_id_r)*WIDTH +: WIDTH];
    end

    // Snapshot sequencer with registered target controls and snapshot stream.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= S_IDLE;
            mask_r         <= {NUM_REGS{1'b0}};
            idx_r          <= {IDXW{1'b0}};
            exr_r          <= {WIDTH{1'b0}};
            tmo_cnt_r      <= {TW{1'b0}};
            tg_hold_r      <= 1'b0;
            divert_r       <= 1'b0;
            load_exr_r     <= 1'b0;
            exec_r         <= 1'b0;
            force_opcode_r <= {WIDTH{1'b0}};
            snap_wr_r      <= 1'b0;
            snap_idx_r     <= {IDXW{1'b0}};
            snap_data_r    <= {WIDTH{1'b0}};
            snap_err_r     <= 1'b0;
            hit_id_r       <= {BPW{1'b0}};
            hit_count_r    <= 16'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            load_exr_r <= 1'b0;
            exec_r     <= 1'b0;
            snap_wr_r  <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (arm) state_r <= S_ARMED;
                end
                S_ARMED: begin
                    if (hit_any_s) begin
                        state_r   <= S_HOLD;
                        hit_id_r  <= hit_idx_s;
                        mask_r    <= cfg_reg_mask;
                        tg_hold_r <= 1'b1;
                        divert_r  <= 1'b1;
                        busy_r    <= 1'b1;
                        if (hit_count_r != 16'hffff) hit_count_r <= hit_count_r + 16'd1;
                    end else if (disarm) begin
                        state_r <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    exr_r      <= exr_shadow;
                    load_exr_r <= 1'b1;
                    if (mask_r == {NUM_REGS{1'b0}}) begin
                        force_opcode_r <= exr_shadow;
                        state_r        <= S_RESTORE;
                    end else begin
                        idx_r          <= first_idx_s;
                        force_opcode_r <= peek_op(first_idx_s);
                        state_r        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    exec_r  <= 1'b1;
                    state_r <= S_EXEC;
                end
                S_EXEC: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    if (peek_valid || (tmo_cnt_r == TMO_LAST)) begin
                        snap_wr_r   <= 1'b1;
                        snap_idx_r  <= idx_r;
                        snap_data_r <= peek_valid ? peek_data : {WIDTH{1'b0}};
                        snap_err_r  <= ~peek_valid;
                        mask_r      <= mask_rest_s;
                        load_exr_r  <= 1'b1;
                        if (mask_rest_s == {NUM_REGS{1'b0}}) begin
                            force_opcode_r <= exr_r;
                            state_r        <= S_RESTORE;
                        end else begin
                            idx_r          <= next_idx_s;
                            force_opcode_r <= peek_op(next_idx_s);
                            state_r        <= S_LOAD;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                S_RESTORE: begin
                    tg_hold_r <= 1'b0;
                    divert_r  <= 1'b0;
                    done_r    <= 1'b1;
                    state_r   <= S_RELEASE;
                end
                S_RELEASE: begin
                    state_r <= S_PASS;
                end
                S_PASS: begin
                    // All comparators stay blind until the target has moved off the hit address.
                    if (tg_fetch && (tg_code_addr != pass_addr_s)) begin
                        state_r <= cfg_continuous ? S_ARMED : S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    tg_hold_r <= 1'b0;
                    divert_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign tg_hold           = tg_hold_r;
    assign divert_code_bus   = divert_r;
    assign tg_force_load_exr = load_exr_r;
    assign tg_force_exec     = exec_r;
    assign force_opcode      = force_opcode_r;
    assign snap_wr           = snap_wr_r;
    assign snap_idx          = snap_idx_r;
    assign snap_data         = snap_data_r;
    assign snap_err          = snap_err_r;
    assign hit_id            = hit_id_r;
    assign hit_count         = hit_count_r;
    assign busy              = busy_r;
    assign done              = done_r;

endmodule

// File: tb/tb_visor_snapshot_engine.sv
// Directed bench for visor_snapshot_engine: one task per scenario with hand-computed expectations.
module tb_visor_snapshot_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] cfg_bp_addr;
    logic [3:0]  cfg_bp_en;
    logic [15:0] cfg_reg_mask;
    logic        cfg_continuous, arm, disarm, tg_fetch, peek_valid;
    logic [15:0] tg_code_addr, exr_shadow, peek_data;
    logic        tg_hold, divert_code_bus, tg_force_load_exr, tg_force_exec, snap_wr, snap_err, busy, done;
    logic [15:0] force_opcode, snap_data, hit_count;
    logic [3:0]  snap_idx;
    logic [1:0]  hit_id;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ops [16];
    logic [3:0]  s_idx [16];
    logic [15:0] s_data [16];
    logic        s_err [16];
    int          n_op, n_snap, n_done, exec_cyc, snap_cyc, done_cyc;
    bit          hold_ok;

    localparam logic [15:0] RESP_BASE = 16'hbee8;

    always #5 clk = ~clk;

    visor_snapshot_engine dut (
        .clk(clk), .reset_n(reset_n), .cfg_bp_addr(cfg_bp_addr), .cfg_bp_en(cfg_bp_en),
        .cfg_reg_mask(cfg_reg_mask), .cfg_continuous(cfg_continuous), .arm(arm), .disarm(disarm),
        .tg_fetch(tg_fetch), .tg_code_addr(tg_code_addr), .exr_shadow(exr_shadow),
        .peek_valid(peek_valid), .peek_data(peek_data), .tg_hold(tg_hold),
        .divert_code_bus(divert_code_bus), .tg_force_load_exr(tg_force_load_exr),
        .tg_force_exec(tg_force_exec), .force_opcode(force_opcode), .snap_wr(snap_wr),
        .snap_idx(snap_idx), .snap_data(snap_data), .snap_err(snap_err), .hit_id(hit_id),
        .hit_count(hit_count), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; arm = 1'b0; disarm = 1'b0; tg_fetch = 1'b0; tg_code_addr = 16'h0000;
        peek_valid = 1'b0; peek_data = 16'h0000;
        tick; tick;
        reset_n = 1'b1;
    endtask

    task automatic arm_pulse;
        arm = 1'b1; tick; arm = 1'b0;
    endtask

    // Hits at addr, then plays the target: answers each exec one cycle later when respond is set.
    task automatic run_snapshot(input logic [15:0] addr, input bit respond, input int budget);
        int cyc;
        bit exec_prev;
        n_op = 0; n_snap = 0; n_done = 0; exec_cyc = -1; snap_cyc = -1; done_cyc = -1; hold_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ops[k] = 16'h0000; s_idx[k] = 4'h0; s_data[k] = 16'h0000; s_err[k] = 1'b0;
        end
        tg_fetch = 1'b1; tg_code_addr = addr; tick; tg_fetch = 1'b0;
        exec_prev = 1'b0;
        cyc = 0;
        while (n_done == 0 && cyc < budget) begin
            if (tg_force_load_exr && n_op < 16) begin ops[n_op] = force_opcode; n_op++; end
            if (tg_force_exec && exec_cyc < 0) exec_cyc = cyc;
            if (snap_wr && n_snap < 16) begin
                s_idx[n_snap] = snap_idx; s_data[n_snap] = snap_data; s_err[n_snap] = snap_err;
                if (snap_cyc < 0) snap_cyc = cyc;
                n_snap++;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            else if (!tg_hold || !divert_code_bus) hold_ok = 1'b0;
            peek_valid = respond && exec_prev;
            peek_data  = RESP_BASE ^ {12'h000, force_opcode[3:0]};
            exec_prev  = tg_force_exec;
            tick;
            cyc++;
        end
        peek_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; arm = 1'b0; disarm = 1'b0; tg_fetch = 1'b0; tg_code_addr = 16'h0000;
        peek_valid = 1'b0; peek_data = 16'h0000;
        tick;
        n_checks++;
        if ({tg_hold, divert_code_bus, tg_force_load_exr, tg_force_exec, force_opcode, snap_wr, snap_idx,
             snap_data, snap_err, hit_id, hit_count, busy, done} !== 73'd0) begin
            n_fail++; $display("FAIL reset_outputs: got hold=%b busy=%b op=%h cnt=%h want all 0", tg_hold, busy, force_opcode, hit_count);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_hit;
        do_reset;
        cfg_reg_mask = 16'h0080;
        arm_pulse;
        n_checks++; if (busy !== 1'b0 || tg_hold !== 1'b0) begin n_fail++; $display("FAIL armed_idle: busy=%b hold=%b want 0 0", busy, tg_hold); end
        tg_fetch = 1'b1; tg_code_addr = 16'h0015; tick; tg_fetch = 1'b0;
        n_checks++; if ({tg_hold, divert_code_bus, busy} !== 3'b111) begin n_fail++; $display("FAIL hold_rise: got %b want 111", {tg_hold, divert_code_bus, busy}); end
        tick;
        n_checks++; if (force_opcode !== 16'h7c07 || tg_force_load_exr !== 1'b1 || tg_force_exec !== 1'b0) begin n_fail++; $display("FAIL load_op: op=%h ld=%b ex=%b want 7c07 1 0", force_opcode, tg_force_load_exr, tg_force_exec); end
        tick;
        n_checks++; if (tg_force_exec !== 1'b1 || tg_force_load_exr !== 1'b0) begin n_fail++; $display("FAIL exec_pulse: ex=%b ld=%b want 1 0", tg_force_exec, tg_force_load_exr); end
        tick;
        peek_valid = 1'b1; peek_data = 16'hbeef;
        n_checks++; if (snap_wr !== 1'b0) begin n_fail++; $display("FAIL early_snap: got %b want 0", snap_wr); end
        tick;
        peek_valid = 1'b0;
        n_checks++; if ({snap_wr, snap_idx, snap_data, snap_err} !== {1'b1, 4'd7, 16'hbeef, 1'b0}) begin n_fail++; $display("FAIL snap_entry: wr=%b idx=%0d data=%h err=%b want 1 7 beef 0", snap_wr, snap_idx, snap_data, snap_err); end
        n_checks++; if (force_opcode !== 16'h1234 || tg_force_load_exr !== 1'b1 || tg_hold !== 1'b1) begin n_fail++; $display("FAIL restore_op: op=%h ld=%b hold=%b want 1234 1 1", force_opcode, tg_force_load_exr, tg_hold); end
        tick;
        n_checks++; if ({done, tg_hold, divert_code_bus, snap_wr} !== 4'b1000) begin n_fail++; $display("FAIL release: got %b want 1000", {done, tg_hold, divert_code_bus, snap_wr}); end
        n_checks++; if (hit_count !== 16'd1 || hit_id !== 2'd0) begin n_fail++; $display("FAIL hit_count1: cnt=%0d id=%0d want 1 0", hit_count, hit_id); end
        tick;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pass_state: done=%b busy=%b want 0 1", done, busy); end
        tg_fetch = 1'b1; tg_code_addr = 16'h0020; tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL oneshot_idle: busy=%b want 0", busy); end
        tg_code_addr = 16'h0015; tick; tg_fetch = 1'b0;
        n_checks++; if (tg_hold !== 1'b0 || hit_count !== 16'd1) begin n_fail++; $display("FAIL idle_no_hit: hold=%b cnt=%0d want 0 1", tg_hold, hit_count); end
    endtask

    task automatic test_multi_mask;
        do_reset;
        cfg_reg_mask = 16'h8005;
        arm_pulse;
        run_snapshot(16'h0015, 1'b1, 80);
        n_checks++; if (n_done !== 1 || n_snap !== 3 || hold_ok !== 1'b1) begin n_fail++; $display("FAIL multi_count: done=%0d snaps=%0d hold_ok=%b want 1 3 1", n_done, n_snap, hold_ok); end
        n_checks++; if ({s_idx[0], s_idx[1], s_idx[2]} !== {4'd0, 4'd2, 4'd15}) begin n_fail++; $display("FAIL multi_idx: got %0d %0d %0d want 0 2 15", s_idx[0], s_idx[1], s_idx[2]); end
        n_checks++; if ({s_data[0], s_data[1], s_data[2], s_err[0], s_err[1], s_err[2]} !== {16'hbee8, 16'hbeea, 16'hbee7, 3'b000}) begin n_fail++; $display("FAIL multi_data: got %h %h %h err %b%b%b want bee8 beea bee7 000", s_data[0], s_data[1], s_data[2], s_err[0], s_err[1], s_err[2]); end
        n_checks++; if (n_op !== 4 || {ops[0], ops[1], ops[2], ops[3]} !== {16'h7c00, 16'h7c02, 16'h7c0f, 16'h1234}) begin n_fail++; $display("FAIL multi_ops: n=%0d got %h %h %h %h want 7c00 7c02 7c0f 1234", n_op, ops[0], ops[1], ops[2], ops[3]); end
        n_checks++; if (snap_cyc - exec_cyc !== 2) begin n_fail++; $display("FAIL multi_latency: got %0d want 2", snap_cyc - exec_cyc); end
    endtask

    task automatic test_simultaneous;
        do_reset;
        cfg_bp_addr = {16'h0040, 16'h0099, 16'h0040, 16'h0015};
        cfg_bp_en   = 4'b1011;
        cfg_reg_mask = 16'h0001;
        arm_pulse;
        run_snapshot(16'h0040, 1'b1, 40);
        n_checks++; if (hit_id !== 2'd1 || n_done !== 1) begin n_fail++; $display("FAIL simul_hit_id: id=%0d done=%0d want 1 1", hit_id, n_done); end
        cfg_bp_addr = {16'h0000, 16'h0000, 16'h0000, 16'h0015};
        cfg_bp_en   = 4'b0001;
    endtask

    task automatic test_pass_once;
        bit blocked;
        do_reset;
        cfg_continuous = 1'b1;
        cfg_reg_mask = 16'h0001;
        arm_pulse;
        run_snapshot(16'h0015, 1'b1, 40);
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL pass_first: done=%0d want 1", n_done); end
        blocked = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tg_fetch = 1'b1; tg_code_addr = 16'h0015; tick;
            if (tg_hold !== 1'b0 || busy !== 1'b1) blocked = 1'b0;
        end
        n_checks++; if (blocked !== 1'b1 || hit_count !== 16'd1) begin n_fail++; $display("FAIL pass_blocked: blocked=%b cnt=%0d want 1 1", blocked, hit_count); end
        tg_code_addr = 16'h0016; tick; tg_fetch = 1'b0;
        n_checks++; if (busy !== 1'b0 || tg_hold !== 1'b0) begin n_fail++; $display("FAIL pass_rearm: busy=%b hold=%b want 0 0", busy, tg_hold); end
        run_snapshot(16'h0015, 1'b1, 40);
        n_checks++; if (n_done !== 1 || hit_count !== 16'd2) begin n_fail++; $display("FAIL pass_second: done=%0d cnt=%0d want 1 2", n_done, hit_count); end
        cfg_continuous = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset;
        cfg_reg_mask = 16'h0002;
        arm_pulse;
        run_snapshot(16'h0015, 1'b0, 80);
        n_checks++; if (n_snap !== 1 || {s_idx[0], s_data[0], s_err[0]} !== {4'd1, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL tmo_entry: n=%0d idx=%0d data=%h err=%b want 1 1 0000 1", n_snap, s_idx[0], s_data[0], s_err[0]); end
        n_checks++; if (snap_cyc - exec_cyc !== 16) begin n_fail++; $display("FAIL tmo_latency: got %0d want 16", snap_cyc - exec_cyc); end
        n_checks++; if (n_done !== 1 || n_op !== 2 || ops[0] !== 16'h7c01 || ops[1] !== 16'h1234) begin n_fail++; $display("FAIL tmo_restore: done=%0d n=%0d ops %h %h want 1 2 7c01 1234", n_done, n_op, ops[0], ops[1]); end
    endtask

    task automatic test_reset_mid_wait;
        do_reset;
        cfg_reg_mask = 16'h0001;
        arm_pulse;
        tg_fetch = 1'b1; tg_code_addr = 16'h0015; tick; tg_fetch = 1'b0;
        tick; tick; tick;
        n_checks++; if (tg_hold !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL in_wait: hold=%b busy=%b want 1 1", tg_hold, busy); end
        reset_n = 1'b0; tick;
        n_checks++;
        if ({tg_hold, divert_code_bus, tg_force_load_exr, tg_force_exec, force_opcode, snap_wr, snap_idx,
             snap_data, snap_err, hit_id, hit_count, busy, done} !== 73'd0) begin
            n_fail++; $display("FAIL midreset_outputs: hold=%b div=%b busy=%b op=%h cnt=%h want all 0", tg_hold, divert_code_bus, busy, force_opcode, hit_count);
        end
        reset_n = 1'b1;
        tg_fetch = 1'b1; tg_code_addr = 16'h0015; tick; tg_fetch = 1'b0;
        n_checks++; if (tg_hold !== 1'b0 || hit_count !== 16'd0) begin n_fail++; $display("FAIL unarmed_no_hit: hold=%b cnt=%0d want 0 0", tg_hold, hit_count); end
        arm_pulse;
        run_snapshot(16'h0015, 1'b1, 40);
        n_checks++; if (n_done !== 1 || hit_count !== 16'd1) begin n_fail++; $display("FAIL rearm_after_reset: done=%0d cnt=%0d want 1 1", n_done, hit_count); end
    endtask

    task automatic test_empty_mask;
        do_reset;
        cfg_reg_mask = 16'h0000;
        arm_pulse;
        run_snapshot(16'h0015, 1'b1, 40);
        n_checks++; if (n_snap !== 0 || n_done !== 1 || done_cyc !== 2) begin n_fail++; $display("FAIL empty_seq: snaps=%0d done=%0d at %0d want 0 1 2", n_snap, n_done, done_cyc); end
        n_checks++; if (n_op !== 1 || ops[0] !== 16'h1234) begin n_fail++; $display("FAIL empty_restore: n=%0d op=%h want 1 1234", n_op, ops[0]); end
    endtask

    task automatic test_disarm;
        do_reset;
        cfg_reg_mask = 16'h0001;
        arm_pulse;
        disarm = 1'b1; tick; disarm = 1'b0;
        tg_fetch = 1'b1; tg_code_addr = 16'h0015; tick; tg_fetch = 1'b0;
        n_checks++; if (tg_hold !== 1'b0) begin n_fail++; $display("FAIL disarm_idle: hold=%b want 0", tg_hold); end
        arm_pulse;
        disarm = 1'b1; tg_fetch = 1'b1; tick; disarm = 1'b0; tg_fetch = 1'b0;
        n_checks++; if (tg_hold !== 1'b1 || hit_count !== 16'd1) begin n_fail++; $display("FAIL hit_beats_disarm: hold=%b cnt=%0d want 1 1", tg_hold, hit_count); end
    endtask

    initial begin
        cfg_bp_addr    = {16'h0000, 16'h0000, 16'h0000, 16'h0015};
        cfg_bp_en      = 4'b0001;
        cfg_reg_mask   = 16'h0000;
        cfg_continuous = 1'b0;
        exr_shadow     = 16'h1234;
        test_reset;
        test_single_hit;
        test_multi_mask;
        test_simultaneous;
        test_pass_once;
        test_timeout;
        test_reset_mid_wait;
        test_empty_mask;
        test_disarm;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
